semaforo_cruce_ctrl: RTL and testbench
======================================

Name: semaforo_cruce_ctrl

Overview:
Phase scheduler for a two-road intersection: main road A, side road B, plus a pedestrian crossing. It shares the crossing between three requesters: road A (the default holder), the road-B vehicle sensor and the pedestrian button. It sequences the light outputs through timed phases with all-red clearances in between. Timing counts a shared 1-cycle `Tick` strobe, so durations are in ticks, not clocks.

Parameters:
- W, 8, timer width in bits.
- T_TODO_ROJO, 2, all-red clearance duration in ticks (>=1).
- T_MIN_VERDE_A, 10, minimum road-A green in ticks (>=1).
- T_VERDE_B, 6, road-B green in ticks (>=1).
- T_AMARILLO, 3, yellow duration in ticks for both roads (>=1).
- T_PEATON, 8, pedestrian walk duration in ticks (>=1).

Ports:
- Clk  in  1  clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Tick  in  1  timebase strobe, one Clk wide.
- Sensor_B  in  1  vehicle waiting on road B (level or pulse).
- Boton_Peaton  in  1  pedestrian button (level or pulse).
- Rojo_A  out  1  road A red.
- Amarillo_A  out  1  road A yellow.
- Verde_A  out  1  road A green.
- Rojo_B  out  1  road B red.
- Amarillo_B  out  1  road B yellow.
- Verde_B  out  1  road B green.
- Pasar_Persona  out  1  pedestrian walk lamp.
- Peticion_Pendiente  out  2  {req_p, req_b} latched requests.
- Estado_Salida  out  4  current state code.

Behaviour:
State codes:
- 0 ROJO_INI
- 1 A_VERDE
- 2 A_AMARILLO
- 3 ROJO_AB
- 4 B_VERDE
- 5 B_AMARILLO
- 6 ROJO_BA
- 7 PEATON
- 8 NOCHE (only with the optional feature)

Outputs:
- Moore outputs, decoded from the state register only; they change in the same cycle as Estado_Salida.
- Exactly one lamp per road is lit in every state except NOCHE.
- Road A is red except in A_VERDE (green) and A_AMARILLO (yellow).
- Road B is red except in B_VERDE (green) and B_AMARILLO (yellow).
- Pasar_Persona=1 only in PEATON.

Reset:
- Reset=0 forces, asynchronously: state 0, timer 0, req_p=req_b=0.
- Outputs during reset: Rojo_A=Rojo_B=1, every other lamp 0, Estado_Salida=0.
- Asserting Reset mid-phase forces all-red immediately, without waiting for a clock edge.

Timer:
- Cleared to 0 on every state entry.
- Increments only on cycles where Tick=1, and saturates at 2^W-1.
- A timed state of duration T exits on the edge where Tick=1 and timer==T-1, so the state lasts exactly T ticks.
- Tick=0 freezes both the timer and the state.

Request latches:
- req_b is set on any edge where Sensor_B=1 and cleared on entry to B_VERDE.
- req_p is set on any edge where Boton_Peaton=1 and cleared on entry to PEATON.
- Clear wins over set in the same cycle: that request is the one being served.

Transitions:
- ROJO_INI -> A_VERDE after T_TODO_ROJO.
- A_VERDE: stays indefinitely. Exits to A_AMARILLO on a Tick edge with timer>=T_MIN_VERDE_A-1 and (req_b|req_p).
- A_AMARILLO -> ROJO_AB after T_AMARILLO.
- ROJO_AB -> PEATON if req_p, else B_VERDE, after T_TODO_ROJO.
- PEATON -> B_VERDE if req_b, else ROJO_BA, after T_PEATON. Vehicles stay all-red throughout PEATON.
- B_VERDE -> B_AMARILLO after T_VERDE_B.
- B_AMARILLO -> ROJO_BA after T_AMARILLO.
- ROJO_BA -> A_VERDE after T_TODO_ROJO.
- When both requests are pending, PEATON is served before B_VERDE.
- Any unused state code (9..15) goes to ROJO_INI on the next edge.

Optional Feature:
Macro MODO_NOCHE_EN.
- Defined:
  - Adds input `Modo_Noche` (1 bit).
  - In A_VERDE, Modo_Noche=1 acts as a request.
  - At ROJO_AB or ROJO_BA exit with Modo_Noche=1, the next state is NOCHE (overrides all other choices).
  - In NOCHE: Amarillo_A=Amarillo_B=blink bit (0 on entry, toggles every Tick); all red/green lamps, and Pasar_Persona, are 0.
  - Requests keep latching in NOCHE.
  - NOCHE -> ROJO_INI on the first Tick edge with Modo_Noche=0.
- Undefined:
  - No port and no state 8.
  - A_VERDE exits only on (req_b|req_p).

Test Plan (default parameters, Tick=1 every cycle unless stated):
1. Release Reset, no requests -> Estado_Salida=0 for 2 cycles, then 1 held for 50+ cycles with Verde_A=1, Rojo_B=1, Pasar_Persona=0.
2. Pulse Sensor_B for 1 cycle at A_VERDE cycle 3 -> A_VERDE exits at its 10th tick. Sequence 2(3 cycles), 3(2), 4(6), 5(3), 6(2), then 1. Peticion_Pendiente=2'b01 until entry to state 4, 2'b00 after.
3. Pulse Boton_Peaton only -> sequence 2(3), 3(2), 7(8) with Pasar_Persona=1 and Rojo_A=Rojo_B=1, then 6(2), then 1.
4. Assert Sensor_B and Boton_Peaton in the same cycle -> sequence 2, 3, 7, 4, 5, 6, 1. No state is skipped or repeated.
5. Drive Reset=0 between clock edges while in state 4 -> Verde_B=0, Rojo_A=Rojo_B=1, Estado_Salida=0 with no edge. Peticion_Pendiente=0.
6. Hold Tick=0 for 20 cycles in state 2 -> state and timer frozen. Tick resumes -> remaining yellow ticks complete with the correct total of 3. With MODO_NOCHE_EN and Modo_Noche=1: exits to 8 after the next all-red phase and Amarillo_A toggles each tick.

Source files
------------

// File: rtl/semaforo_cruce_ctrl.sv
// Two-road intersection phase scheduler with pedestrian crossing; timing in Tick strobes.
// Optional night blinking mode under MODO_NOCHE_EN.
module semaforo_cruce_ctrl #(
  parameter int W             = 8,
  parameter int T_TODO_ROJO   = 2,
  parameter int T_MIN_VERDE_A = 10,
  parameter int T_VERDE_B     = 6,
  parameter int T_AMARILLO    = 3,
  parameter int T_PEATON      = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Tick,
  input  logic       Sensor_B,
  input  logic       Boton_Peaton,
`ifdef MODO_NOCHE_EN
  input  logic       Modo_Noche,
`endif
  output logic       Rojo_A,
  output logic       Amarillo_A,
  output logic       Verde_A,
  output logic       Rojo_B,
  output logic       Amarillo_B,
  output logic       Verde_B,
  output logic       Pasar_Persona,
  output logic [1:0] Peticion_Pendiente,
  output logic [3:0] Estado_Salida
);

  typedef enum logic [3:0] {
    ROJO_INI   = 4'd0,
    A_VERDE    = 4'd1,
    A_AMARILLO = 4'd2,
    ROJO_AB    = 4'd3,
    B_VERDE    = 4'd4,
    B_AMARILLO = 4'd5,
    ROJO_BA    = 4'd6,
`ifdef MODO_NOCHE_EN
    PEATON     = 4'd7,
    NOCHE      = 4'd8
`else
    PEATON     = 4'd7
`endif
  } state_t;

  // Exit thresholds: a state of duration T leaves when the timer reads T-1 on a tick.
  localparam logic [W-1:0] LIM_ROJO  = W'(T_TODO_ROJO - 1);
  localparam logic [W-1:0] LIM_VA    = W'(T_MIN_VERDE_A - 1);
  localparam logic [W-1:0] LIM_VB    = W'(T_VERDE_B - 1);
  localparam logic [W-1:0] LIM_AMA   = W'(T_AMARILLO - 1);
  localparam logic [W-1:0] LIM_PEA   = W'(T_PEATON - 1);

  state_t       state, state_nxt;
  logic [W-1:0] timer;
  logic         req_b, req_p;
  logic         night;

`ifdef MODO_NOCHE_EN
  logic blink;
  assign night = Modo_Noche;
`else
  assign night = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ROJO_INI:   if (Tick && timer == LIM_ROJO) state_nxt = A_VERDE;
      A_VERDE:    if (Tick && timer >= LIM_VA && (req_b || req_p || night)) state_nxt = A_AMARILLO;
      A_AMARILLO: if (Tick && timer == LIM_AMA) state_nxt = ROJO_AB;
      ROJO_AB: begin
        if (Tick && timer == LIM_ROJO) begin
          state_nxt = req_p ? PEATON : B_VERDE;
`ifdef MODO_NOCHE_EN
          if (Modo_Noche) state_nxt = NOCHE;
`endif
        end
      end
      B_VERDE:    if (Tick && timer == LIM_VB) state_nxt = B_AMARILLO;
      B_AMARILLO: if (Tick && timer == LIM_AMA) state_nxt = ROJO_BA;
      ROJO_BA: begin
        if (Tick && timer == LIM_ROJO) begin
          state_nxt = A_VERDE;
`ifdef MODO_NOCHE_EN
          if (Modo_Noche) state_nxt = NOCHE;
`endif
        end
      end
      PEATON:     if (Tick && timer == LIM_PEA) state_nxt = req_b ? B_VERDE : ROJO_BA;
`ifdef MODO_NOCHE_EN
      NOCHE:      if (Tick && !Modo_Noche) state_nxt = ROJO_INI;
`endif
      default:    state_nxt = ROJO_INI;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= ROJO_INI;
      timer <= '0;
      req_b <= 1'b0;
      req_p <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        timer <= '0;
      else if (Tick && timer != '1)
        timer <= timer + W'(1);
      // Clearing on entry to the serving state beats a same-cycle set.
      req_b <= (req_b | Sensor_B) & ~(state_nxt == B_VERDE && state != B_VERDE);
      req_p <= (req_p | Boton_Peaton) & ~(state_nxt == PEATON && state != PEATON);
    end
  end

`ifdef MODO_NOCHE_EN
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)
      blink <= 1'b0;
    else if (state_nxt != state)
      blink <= 1'b0;
    else if (Tick && state == NOCHE)
      blink <= ~blink;
  end
`endif

  always_comb begin
    Rojo_A        = 1'b1;
    Amarillo_A    = 1'b0;
    Verde_A       = 1'b0;
    Rojo_B        = 1'b1;
    Amarillo_B    = 1'b0;
    Verde_B       = 1'b0;
    Pasar_Persona = 1'b0;
    case (state)
      A_VERDE:    begin Rojo_A = 1'b0; Verde_A    = 1'b1; end
      A_AMARILLO: begin Rojo_A = 1'b0; Amarillo_A = 1'b1; end
      B_VERDE:    begin Rojo_B = 1'b0; Verde_B    = 1'b1; end
      B_AMARILLO: begin Rojo_B = 1'b0; Amarillo_B = 1'b1; end
      PEATON:     Pasar_Persona = 1'b1;
`ifdef MODO_NOCHE_EN
      NOCHE: begin
        Rojo_A     = 1'b0;
        Rojo_B     = 1'b0;
        Amarillo_A = blink;
        Amarillo_B = blink;
      end
`endif
      default: ;
    endcase
  end

  assign Peticion_Pendiente = {req_p, req_b};
  assign Estado_Salida      = state;

endmodule

// File: tb/tb_semaforo_cruce_ctrl.sv
// Directed bench: phase-level reference model checked every cycle, plus literal run-length checks.
module tb_semaforo_cruce_ctrl;

  localparam int TR = 2, TMV = 10, TVB = 6, TAM = 3, TPE = 8;

  logic       Clk, Reset, Tick, Sensor_B, Boton_Peaton;
  logic       Rojo_A, Amarillo_A, Verde_A, Rojo_B, Amarillo_B, Verde_B, Pasar_Persona;
  logic [1:0] Peticion_Pendiente;
  logic [3:0] Estado_Salida;
`ifdef MODO_NOCHE_EN
  logic       Modo_Noche;
`endif

  int total = 0;
  int bad   = 0;

  semaforo_cruce_ctrl dut (
    .Clk(Clk), .Reset(Reset), .Tick(Tick), .Sensor_B(Sensor_B), .Boton_Peaton(Boton_Peaton),
`ifdef MODO_NOCHE_EN
    .Modo_Noche(Modo_Noche),
`endif
    .Rojo_A(Rojo_A), .Amarillo_A(Amarillo_A), .Verde_A(Verde_A),
    .Rojo_B(Rojo_B), .Amarillo_B(Amarillo_B), .Verde_B(Verde_B),
    .Pasar_Persona(Pasar_Persona), .Peticion_Pendiente(Peticion_Pendiente),
    .Estado_Salida(Estado_Salida)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_val(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference model: phase name, ticks spent in it, and the two pending requests.
  int m_st = 0, m_tk = 0, m_nx = 0;
  bit m_rb = 0, m_rp = 0;

  function automatic int dur(input int s);
    case (s)
      0, 3, 6: return TR;
      2, 5:    return TAM;
      4:       return TVB;
      7:       return TPE;
      default: return 0;
    endcase
  endfunction

  // {Rojo_A, Amarillo_A, Verde_A, Rojo_B, Amarillo_B, Verde_B, Pasar_Persona}
  function automatic logic [6:0] lamps(input int s);
    logic [2:0] a, b;
    a = (s == 1) ? 3'b001 : (s == 2) ? 3'b010 : 3'b100;
    b = (s == 4) ? 3'b001 : (s == 5) ? 3'b010 : 3'b100;
    return {a, b, (s == 7)};
  endfunction

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      m_st = 0; m_tk = 0; m_rb = 0; m_rp = 0;
    end else begin
      m_nx = m_st;
      if (Tick) begin
        if (m_st == 1) begin
          if (m_tk + 1 >= TMV && (m_rb || m_rp)) m_nx = 2;
        end else if (m_tk + 1 == dur(m_st)) begin
          case (m_st)
            0: m_nx = 1;
            2: m_nx = 3;
            3: m_nx = m_rp ? 7 : 4;
            4: m_nx = 5;
            5: m_nx = 6;
            6: m_nx = 1;
            7: m_nx = m_rb ? 4 : 6;
            default: m_nx = 0;
          endcase
        end
      end
      m_rb = (m_rb || Sensor_B)     && !(m_nx == 4 && m_st != 4);
      m_rp = (m_rp || Boton_Peaton) && !(m_nx == 7 && m_st != 7);
      if (m_nx != m_st) m_tk = 0;
      else if (Tick) m_tk++;
      m_st = m_nx;
    end
  end

  always @(negedge Clk) begin
    logic [12:0] act, exp;
    act = {Rojo_A, Amarillo_A, Verde_A, Rojo_B, Amarillo_B, Verde_B, Pasar_Persona,
           Peticion_Pendiente, Estado_Salida};
    exp = {lamps(m_st), m_rp, m_rb, 4'(m_st)};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL model_cmp t=%0t actual=%b expected=%b", $time, act, exp);
    end
  end

  // Expected phase sequence and run lengths (cycles); the last entry is only checked for presence.
  int ec[$];
  int el[$];

  task automatic expect_runs(input string tag);
    int cnt;
    for (int i = 0; i < ec.size(); i++) begin
      check_val($sformatf("%s_state%0d", tag, i), int'(Estado_Salida), ec[i]);
      if (i == ec.size() - 1) break;
      cnt = 0;
      while (int'(Estado_Salida) == ec[i] && cnt < el[i] + 40) begin
        cnt++;
        @(negedge Clk);
      end
      check_val($sformatf("%s_len%0d", tag, i), cnt, el[i]);
    end
  endtask

  task automatic wait_state(input int code, input int budget);
    int n = 0;
    while (int'(Estado_Salida) != code && n < budget) begin
      n++;
      @(negedge Clk);
    end
    check_val($sformatf("wait_state%0d", code), int'(Estado_Salida), code);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    Reset = 1'b0; Tick = 1'b1; Sensor_B = 1'b0; Boton_Peaton = 1'b0;
`ifdef MODO_NOCHE_EN
    Modo_Noche = 1'b0;
`endif
    repeat (3) @(negedge Clk);
    check_val("rst_estado", int'(Estado_Salida), 0);
    check_val("rst_lamps", int'({Rojo_A, Amarillo_A, Verde_A, Rojo_B, Amarillo_B, Verde_B, Pasar_Persona}), 7'b1001000);
    check_val("rst_pet", int'(Peticion_Pendiente), 0);
    Reset = 1'b1;

    // 1: idle, road A holds green
    ec = '{0, 1}; el = '{TR};
    expect_runs("t1");
    repeat (60) @(negedge Clk);
    check_val("t1_hold_state", int'(Estado_Salida), 1);
    check_val("t1_hold_verde_a", int'(Verde_A), 1);

    // Late side-road request after a long green exits on the next tick
    Sensor_B = 1'b1; @(negedge Clk); Sensor_B = 1'b0;
    check_val("t1b_pet", int'(Peticion_Pendiente), 1);
    ec = '{1, 2, 3, 4, 5, 6, 1}; el = '{1, 3, 2, 6, 3, 2};
    expect_runs("t1b");

    // 2: side-road pulse at A_VERDE cycle 3, A_VERDE lasts 10 ticks total
    repeat (2) @(negedge Clk);
    Sensor_B = 1'b1; @(negedge Clk); Sensor_B = 1'b0;
    ec = '{1, 2, 3, 4, 5, 6, 1}; el = '{7, 3, 2, 6, 3, 2};
    expect_runs("t2");

    // 3: pedestrian only
    Boton_Peaton = 1'b1; @(negedge Clk); Boton_Peaton = 1'b0;
    check_val("t3_pet", int'(Peticion_Pendiente), 2);
    ec = '{1, 2, 3, 7, 6, 1}; el = '{9, 3, 2, 8, 2};
    expect_runs("t3");

    // 4: both requests in the same cycle, pedestrian first
    Sensor_B = 1'b1; Boton_Peaton = 1'b1; @(negedge Clk);
    Sensor_B = 1'b0; Boton_Peaton = 1'b0;
    check_val("t4_pet", int'(Peticion_Pendiente), 3);
    ec = '{1, 2, 3, 7, 4, 5, 6, 1}; el = '{9, 3, 2, 8, 6, 3, 2};
    expect_runs("t4");

    // 6: Tick held low for 20 cycles in the middle of A_AMARILLO
    Sensor_B = 1'b1; @(negedge Clk); Sensor_B = 1'b0;
    wait_state(2, 40);
    @(negedge Clk);
    Tick = 1'b0;
    repeat (20) @(negedge Clk);
    check_val("t6_frozen", int'(Estado_Salida), 2);
    Tick = 1'b1;
    ec = '{2, 3, 4, 5, 6, 1}; el = '{2, 2, 6, 3, 2};
    expect_runs("t6");

    // 5: asynchronous reset between edges while in B_VERDE with a request pending
    Sensor_B = 1'b1; @(negedge Clk); Sensor_B = 1'b0;
    wait_state(4, 40);
    Sensor_B = 1'b1;
    @(posedge Clk);
    #2;
    Sensor_B = 1'b0;
    check_val("t5_pre_estado", int'(Estado_Salida), 4);
    check_val("t5_pre_pet", int'(Peticion_Pendiente), 1);
    Reset = 1'b0;
    #1;
    check_val("t5_estado", int'(Estado_Salida), 0);
    check_val("t5_verde_b", int'(Verde_B), 0);
    check_val("t5_rojos", int'({Rojo_A, Rojo_B}), 3);
    check_val("t5_pet", int'(Peticion_Pendiente), 0);
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    ec = '{0, 1}; el = '{TR};
    expect_runs("t5_restart");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
